// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte streams,
// with packet lock and optional source-tag bytes on source changes.
module uart_tx_scheduler #(
    parameter int         NUM_REQ    = 4,
    parameter int         SRC_W      = 2,
    parameter bit         TAG_ENABLE = 1'b1,
    parameter logic [7:0] TAG_BASE   = 8'hA0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart_transmit,
    output logic [7:0]             uart_tx_byte,
    input  logic                   uart_tx_free,
    output logic                   busy,
    output logic [SRC_W-1:0]       cur_src
);

    localparam logic [2:0] S_ARB    = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAITLO = 3'd2;
    localparam logic [2:0] S_WAITHI = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;

    logic [2:0]         state_r;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic               lock_r;
    logic [SRC_W-1:0]   last_src_r;
    logic               last_src_valid_r;
    logic               tag_pend_r;
    logic [SRC_W-1:0]   cur_src_r;
    logic [7:0]         tx_byte_r;
    logic               transmit_r;
    logic [NUM_REQ-1:0] req_ready_r;
    logic               busy_r;

    logic               found_s;
    logic [SRC_W-1:0]   winner_s;
    logic [SRC_W-1:0]   idx_s;
    logic               need_tag_s;
    logic [7:0]         win_data_s;
    logic               win_last_s;
    logic [7:0]         cur_data_s;
    logic               cur_last_s;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        if (v == SRC_W'(NUM_REQ - 1)) begin
            return {SRC_W{1'b0}};
        end else begin
            return v + SRC_W'(1);
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r      = {NUM_REQ{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] tag_of(input logic [SRC_W-1:0] idx);
        return TAG_BASE | {{(8-SRC_W){1'b0}}, idx};
    endfunction

    // Winner selection: locked source only, else first valid from rr_ptr in wrap order
    always_comb begin
        found_s  = 1'b0;
        winner_s = {SRC_W{1'b0}};
        idx_s    = rr_ptr_r;
        if (lock_r) begin
            found_s  = req_valid[cur_src_r];
            winner_s = cur_src_r;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found_s && req_valid[idx_s]) begin
                    found_s  = 1'b1;
                    winner_s = idx_s;
                end else begin
                    found_s  = found_s;
                end
                idx_s = wrap_inc(idx_s);
            end
        end
    end

    // Byte/last selection for the winner and the granted source, plus tag decision
    always_comb begin
        win_data_s = req_data[{winner_s, 3'b000} +: 8];
        win_last_s = req_last[winner_s];
        cur_data_s = req_data[{cur_src_r, 3'b000} +: 8];
        cur_last_s = req_last[cur_src_r];
        if (TAG_ENABLE && (!last_src_valid_r || (winner_s != last_src_r))) begin
            need_tag_s = 1'b1;
        end else begin
            need_tag_s = 1'b0;
        end
    end

    // Scheduler FSM and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= S_ARB;
            rr_ptr_r         <= {SRC_W{1'b0}};
            lock_r           <= 1'b0;
            last_src_r       <= {SRC_W{1'b0}};
            last_src_valid_r <= 1'b0;
            tag_pend_r       <= 1'b0;
            cur_src_r        <= {SRC_W{1'b0}};
            tx_byte_r        <= 8'h00;
            transmit_r       <= 1'b0;
            req_ready_r      <= {NUM_REQ{1'b0}};
            busy_r           <= 1'b0;
        end else begin
            req_ready_r <= {NUM_REQ{1'b0}};
            transmit_r  <= 1'b0;
            case (state_r)
                S_ARB: begin
                    if (found_s) begin
                        cur_src_r <= winner_s;
                        state_r   <= S_ISSUE;
                        busy_r    <= 1'b1;
                        if (need_tag_s) begin
                            tx_byte_r  <= tag_of(winner_s);
                            tag_pend_r <= 1'b1;
                        end else begin
                            tx_byte_r   <= win_data_s;
                            req_ready_r <= onehot(winner_s);
                            lock_r      <= ~win_last_s;
                            if (win_last_s) begin
                                rr_ptr_r <= wrap_inc(winner_s);
                            end else begin
                                rr_ptr_r <= rr_ptr_r;
                            end
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (uart_tx_free) begin
                        transmit_r <= 1'b1;
                        state_r    <= S_WAITLO;
                    end else begin
                        state_r <= S_ISSUE;
                    end
                end
                S_WAITLO: begin
                    // tx_free dropping is the UART taking the byte
                    if (!uart_tx_free) begin
                        state_r <= S_WAITHI;
                    end else begin
                        state_r <= S_WAITLO;
                    end
                end
                S_WAITHI: begin
                    if (uart_tx_free) begin
                        if (tag_pend_r) begin
                            tag_pend_r       <= 1'b0;
                            last_src_r       <= cur_src_r;
                            last_src_valid_r <= 1'b1;
                            state_r          <= S_DATA;
                        end else begin
                            state_r <= S_ARB;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= S_WAITHI;
                    end
                end
                S_DATA: begin
                    // Source is still holding the byte that triggered the tag
                    tx_byte_r   <= cur_data_s;
                    req_ready_r <= onehot(cur_src_r);
                    lock_r      <= ~cur_last_s;
                    if (cur_last_s) begin
                        rr_ptr_r <= wrap_inc(cur_src_r);
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                    state_r <= S_ISSUE;
                end
                default: begin
                    state_r    <= S_ARB;
                    busy_r     <= 1'b0;
                    tag_pend_r <= 1'b0;
                    lock_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_r;
    assign uart_transmit = transmit_r;
    assign uart_tx_byte  = tx_byte_r;
    assign busy          = busy_r;
    assign cur_src       = cur_src_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: queued sources, a small UART model,
// and a second tag-less instance driven by hand.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        uart_tx_free;
    logic        busy;
    logic [1:0]  cur_src;

    logic [3:0]  v0 = 4'h0;
    logic [31:0] d0 = 32'h0;
    logic [3:0]  l0 = 4'h0;
    logic [3:0]  rdy0;
    logic        tx0;
    logic [7:0]  byte0;
    logic        free0 = 1'b1;
    logic        busy0;
    logic [1:0]  cur0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] mem [4][64];
    logic [5:0] head [4] = '{default: 6'd0};
    logic [5:0] tail [4] = '{default: 6'd0};
    int         rdy_cnt [4] = '{default: 0};

    logic [7:0] cap_mem [256];
    int         cap_cnt  = 0;
    logic       free_r   = 1'b1;
    int         busy_cnt = 0;
    logic       prev_tx  = 1'b0;
    int viol_free = 0, viol_dbl = 0, viol_rdy = 0, viol_oh = 0, viol0 = 0;
    int tx0_cnt = 0;

    uart_tx_scheduler u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_transmit(uart_transmit),
        .uart_tx_byte(uart_tx_byte), .uart_tx_free(uart_tx_free), .busy(busy),
        .cur_src(cur_src)
    );

    uart_tx_scheduler #(.TAG_ENABLE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_data(d0), .req_last(l0),
        .req_ready(rdy0), .uart_transmit(tx0), .uart_tx_byte(byte0),
        .uart_tx_free(free0), .busy(busy0), .cur_src(cur0)
    );

    always #5 clk = ~clk;

    assign uart_tx_free = free_r;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (head[i] != tail[i]);
            req_data[8*i +: 8] = mem[i][head[i]][7:0];
            req_last[i]        = mem[i][head[i]][8];
        end
    end

    // UART model (busy 3 cycles after each launch) and source-side bookkeeping
    always @(posedge clk) begin
        prev_tx <= uart_transmit;
        if (uart_transmit && uart_tx_free) begin
            cap_mem[cap_cnt] <= uart_tx_byte;
            cap_cnt  <= cap_cnt + 1;
            free_r   <= 1'b0;
            busy_cnt <= 3;
        end else if (!free_r) begin
            if (busy_cnt == 0) free_r <= 1'b1;
            else busy_cnt <= busy_cnt - 1;
        end
        if (uart_transmit && !uart_tx_free) viol_free <= viol_free + 1;
        if (uart_transmit && prev_tx) viol_dbl <= viol_dbl + 1;
        if (!$onehot0(req_ready)) viol_oh <= viol_oh + 1;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
                head[i]    <= head[i] + 6'd1;
                rdy_cnt[i] <= rdy_cnt[i] + 1;
                if (!req_valid[i] || uart_tx_byte !== mem[i][head[i]][7:0])
                    viol_rdy <= viol_rdy + 1;
            end
        end
        if (tx0) tx0_cnt <= tx0_cnt + 1;
        if (tx0 && !free0) viol0 <= viol0 + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input int s, input logic last, input logic [7:0] d);
        mem[s][tail[s]] = {last, d};
        tail[s] = tail[s] + 6'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_caps(input int target, output bit ok);
        for (int k = 0; k < 400; k++) begin
            if (cap_cnt >= target) break;
            @(negedge clk);
        end
        ok = (cap_cnt >= target);
    endtask

    task automatic wait_idle(output bit ok);
        for (int k = 0; k < 100; k++) begin
            if (!busy && uart_tx_free) break;
            @(negedge clk);
        end
        ok = (!busy && uart_tx_free);
    endtask

    task automatic test_reset();
        int base;
        bit ok;
        push(0, 1'b1, 8'h77);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (uart_transmit !== 1'b0) $display("FAIL rst_transmit: got %b expected 0", uart_transmit); else n_pass++;
        n_checks++; if (req_ready !== 4'h0) $display("FAIL rst_ready: got %h expected 0", req_ready); else n_pass++;
        n_checks++; if (uart_tx_byte !== 8'h00) $display("FAIL rst_byte: got %h expected 00", uart_tx_byte); else n_pass++;
        n_checks++; if (cur_src !== 2'd0) $display("FAIL rst_cur_src: got %0d expected 0", cur_src); else n_pass++;
        base = cap_cnt;
        rst = 1'b1;
        wait_caps(base + 2, ok);
        n_checks++; if (!ok) $display("FAIL rst_drain_timeout: got %0d bytes expected 2", cap_cnt - base); else n_pass++;
        n_checks++; if (cap_mem[base] !== 8'hA0 || cap_mem[base+1] !== 8'h77)
            $display("FAIL rst_drain: got %h %h expected a0 77", cap_mem[base], cap_mem[base+1]); else n_pass++;
        wait_idle(ok);
    endtask

    task automatic test_single_src2();
        int base, r0;
        bit ok;
        do_reset();
        base = cap_cnt;
        r0 = rdy_cnt[2];
        push(2, 1'b1, 8'h11);
        wait_caps(base + 2, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout: got %0d bytes expected 2", cap_cnt - base); else n_pass++;
        n_checks++; if (cap_mem[base] !== 8'hA2) $display("FAIL single_tag: got %h expected a2", cap_mem[base]); else n_pass++;
        n_checks++; if (cap_mem[base+1] !== 8'h11) $display("FAIL single_data: got %h expected 11", cap_mem[base+1]); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_during: got %b expected 1", busy); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL single_idle: busy %b tx_free %b expected 0 1", busy, uart_tx_free); else n_pass++;
        n_checks++; if (rdy_cnt[2] - r0 !== 1) $display("FAIL single_ready_count: got %0d expected 1", rdy_cnt[2] - r0); else n_pass++;
        n_checks++; if (cap_cnt - base !== 2) $display("FAIL single_byte_count: got %0d expected 2", cap_cnt - base); else n_pass++;
    endtask

    task automatic test_round_robin();
        int base;
        bit ok;
        logic [7:0] exp [8];
        exp = '{8'hA0, 8'h40, 8'hA1, 8'h41, 8'hA0, 8'h40, 8'hA1, 8'h41};
        do_reset();
        base = cap_cnt;
        push(0, 1'b1, 8'h40); push(0, 1'b1, 8'h40);
        push(1, 1'b1, 8'h41); push(1, 1'b1, 8'h41);
        wait_caps(base + 8, ok);
        n_checks++; if (!ok) $display("FAIL rr_timeout: got %0d bytes expected 8", cap_cnt - base); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (cap_mem[base+k] !== exp[k]) $display("FAIL rr_byte%0d: got %h expected %h", k, cap_mem[base+k], exp[k]);
            else n_pass++;
        end
        wait_idle(ok);
    endtask

    task automatic test_packet_lock();
        int base;
        bit ok;
        logic [7:0] exp [6];
        exp = '{8'hA3, 8'h01, 8'h02, 8'h03, 8'hA0, 8'h50};
        do_reset();
        base = cap_cnt;
        push(3, 1'b0, 8'h01); push(3, 1'b0, 8'h02); push(3, 1'b1, 8'h03);
        @(negedge clk);
        push(0, 1'b1, 8'h50);
        wait_caps(base + 6, ok);
        n_checks++; if (!ok) $display("FAIL lock_timeout: got %0d bytes expected 6", cap_cnt - base); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (cap_mem[base+k] !== exp[k]) $display("FAIL lock_byte%0d: got %h expected %h", k, cap_mem[base+k], exp[k]);
            else n_pass++;
        end
        wait_idle(ok);
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'h21, 8'h22, 8'h23};
        do_reset();
        base = cap_cnt;
        push(1, 1'b0, 8'h21); push(1, 1'b1, 8'h22); push(1, 1'b1, 8'h23);
        wait_caps(base + 4, ok);
        n_checks++; if (!ok) $display("FAIL b2b_timeout: got %0d bytes expected 4", cap_cnt - base); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cap_mem[base+k] !== exp[k]) $display("FAIL b2b_byte%0d: got %h expected %h", k, cap_mem[base+k], exp[k]);
            else n_pass++;
        end
        wait_idle(ok);
        n_checks++; if (cap_cnt - base !== 4) $display("FAIL b2b_count: got %0d expected 4", cap_cnt - base); else n_pass++;
    endtask

    task automatic test_no_tag_stall();
        int t0;
        bit seen;
        logic [7:0] seen_byte;
        do_reset();
        free0 = 1'b0;
        v0 = 4'b0100; d0 = 32'h005A_0000; l0 = 4'b0100;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rdy0[2]) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) $display("FAIL notag_ready: got no pulse expected one"); else n_pass++;
        n_checks++; if (byte0 !== 8'h5A) $display("FAIL notag_load: got %h expected 5a", byte0); else n_pass++;
        v0 = 4'h0;
        t0 = tx0_cnt;
        repeat (50) @(negedge clk);
        n_checks++; if (tx0_cnt !== t0) $display("FAIL notag_stall: got %0d pulses expected 0", tx0_cnt - t0); else n_pass++;
        n_checks++; if (busy0 !== 1'b1) $display("FAIL notag_busy: got %b expected 1", busy0); else n_pass++;
        free0 = 1'b1;
        seen_byte = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (tx0) seen_byte = byte0;
        end
        n_checks++; if (tx0_cnt - t0 !== 1) $display("FAIL notag_pulse: got %0d cycles expected 1", tx0_cnt - t0); else n_pass++;
        n_checks++; if (seen_byte !== 8'h5A) $display("FAIL notag_byte: got %h expected 5a", seen_byte); else n_pass++;
        free0 = 1'b0;
        repeat (2) @(negedge clk);
        free0 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy0 !== 1'b0) $display("FAIL notag_idle: got %b expected 0", busy0); else n_pass++;
    endtask

    task automatic test_reset_mid_byte();
        int base, base2;
        bit ok;
        do_reset();
        base = cap_cnt;
        push(1, 1'b1, 8'h55);
        wait_caps(base + 2, ok);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || cur_src !== 2'd1 || uart_tx_byte !== 8'h55)
            $display("FAIL mid_state: got busy %b src %0d byte %h expected 1 1 55", busy, cur_src, uart_tx_byte); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (uart_tx_byte !== 8'h00) $display("FAIL mid_rst_byte: got %h expected 00", uart_tx_byte); else n_pass++;
        n_checks++; if (cur_src !== 2'd0) $display("FAIL mid_rst_src: got %0d expected 0", cur_src); else n_pass++;
        n_checks++; if (uart_transmit !== 1'b0 || req_ready !== 4'h0)
            $display("FAIL mid_rst_strobes: got %b %h expected 0 0", uart_transmit, req_ready); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_idle(ok);
        n_checks++; if (cap_cnt - base !== 2) $display("FAIL mid_no_resend: got %0d bytes expected 2", cap_cnt - base); else n_pass++;
        base2 = cap_cnt;
        push(1, 1'b1, 8'h66);
        wait_caps(base2 + 2, ok);
        n_checks++; if (cap_mem[base2] !== 8'hA1 || cap_mem[base2+1] !== 8'h66)
            $display("FAIL mid_retag: got %h %h expected a1 66", cap_mem[base2], cap_mem[base2+1]); else n_pass++;
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single_src2();
        test_round_robin();
        test_packet_lock();
        test_back_to_back();
        test_no_tag_stall();
        test_reset_mid_byte();
        n_checks++; if (viol_free !== 0) $display("FAIL transmit_while_busy: got %0d expected 0", viol_free); else n_pass++;
        n_checks++; if (viol_dbl !== 0) $display("FAIL transmit_double: got %0d expected 0", viol_dbl); else n_pass++;
        n_checks++; if (viol_rdy !== 0) $display("FAIL ready_vs_byte: got %0d expected 0", viol_rdy); else n_pass++;
        n_checks++; if (viol_oh !== 0) $display("FAIL ready_onehot: got %0d expected 0", viol_oh); else n_pass++;
        n_checks++; if (viol0 !== 0) $display("FAIL notag_transmit_while_busy: got %0d expected 0", viol0); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters using round-robin arbitration with packet lock.
- Drives the UART transmit/tx_byte inputs and follows its tx_free indicator.
- Optionally inserts a source-tag byte whenever the transmitting source changes, so the host can demultiplex streams.
- Sits between the trace/debug byte producers and the UART in the orbtrace top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SRC_W, 2, width of source index (clog2 NUM_REQ, min 1)
TAG_ENABLE, 1, 1 = emit tag byte on source change, 0 = never tag
TAG_BASE, 8'hA0, tag byte value = TAG_BASE | source index (low SRC_W bits of TAG_BASE must be 0)

Ports:
clk  in  1  master clock
rst  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  per-source byte available
req_data  in  8*NUM_REQ  per-source byte, source i at [8i+7:8i]
req_last  in  NUM_REQ  per-source: this byte ends a packet
req_ready  out  NUM_REQ  one-cycle accept pulse per source
uart_transmit  out  1  to UART transmit
uart_tx_byte  out  8  to UART tx_byte
uart_tx_free  in  1  from UART tx_free (high = transmitter idle)
busy  out  1  high in any state other than S_ARB
cur_src  out  SRC_W  index of the currently granted source

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0; state S_ARB; rr_ptr = 0; lock = 0; last_src_valid = 0.
- Requester handshake: a byte transfers when req_ready[i] = 1; at most one req_ready bit is high per cycle.
  - A source must hold req_valid, req_data and req_last stable until it is accepted.
- S_ARB:
  - If lock = 1, only cur_src is eligible; the block waits indefinitely for it and other sources are never granted.
  - Otherwise the grant goes to the first valid source searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0. cur_src takes the winner's index.
  - If TAG_ENABLE=1 and (last_src_valid = 0 or the winner != last_src): load uart_tx_byte = TAG_BASE | winner, set tag_pend = 1, go to S_ISSUE. No req_ready pulse.
  - Else: load uart_tx_byte = req_data[winner], pulse req_ready[winner] this cycle, lock <= ~req_last[winner], go to S_ISSUE.
  - On accept with req_last = 1: rr_ptr <= winner+1 (mod NUM_REQ).
  - No valid source: stay in S_ARB, busy = 0.
- S_ISSUE: wait for uart_tx_free = 1, then assert uart_transmit for exactly one cycle and go to S_WAITLO. uart_tx_byte stays stable from load until S_WAITHI exits.
- S_WAITLO: go to S_WAITHI when uart_tx_free = 0. This is the UART acknowledging the byte; it normally takes 1 cycle.
- S_WAITHI: on uart_tx_free = 1:
  - If tag_pend: clear it, set last_src = cur_src, last_src_valid = 1, then go to S_DATA.
  - Else go to S_ARB.
- S_DATA: load req_data[cur_src], pulse req_ready[cur_src], lock <= ~req_last[cur_src], update rr_ptr as in S_ARB, go to S_ISSUE.
  - req_valid[cur_src] is guaranteed high here by the hold rule.
- uart_transmit is never asserted while uart_tx_free = 0 and never for two consecutive cycles.
- Exactly one UART byte is issued per data acceptance, plus one per tag.
- TAG_ENABLE = 0: S_DATA is unreachable and last_src is unused.
- Simultaneous requests: the source nearest rr_ptr in wrap order wins. A single-byte packet (req_last = 1) rotates priority.
- Reset mid-byte: the scheduler returns to S_ARB immediately. The UART has its own reset; a byte already launched is not re-sent.

Test Plan:
- Single source 2, bytes 0x11 (last=1), TAG_ENABLE=1 -> UART receives 0xA2, 0x11. One req_ready[2] pulse, coincident with loading 0x11. busy falls after the final tx_free rise.
- Sources 0 and 1 both valid from reset, each a single-byte packet (0x40, 0x41), repeated twice -> stream 0xA0,0x40,0xA1,0x41,0xA0,0x40,0xA1,0x41 (round-robin alternation).
- Source 3 packet 0x01,0x02,0x03 (last on 0x03); source 0 valid throughout -> 0xA3,0x01,0x02,0x03 with no interleave, then 0xA0 and source 0 data.
- Source 1 sends two consecutive packets with no other requester -> tag 0xA1 emitted only once.
- TAG_ENABLE=0; hold uart_tx_free low 50 cycles with a byte pending -> uart_transmit stays 0 until tx_free rises, then exactly one 1-cycle pulse with uart_tx_byte = the data.
- Assert rst low mid-S_WAITHI -> all outputs are 0 in the same cycle. After release the next tag is emitted again (last_src_valid cleared).
